// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, stage state type and decode helpers for the
// memory-access/writeback stage of the multi-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LOAD  = 6'b100010;
    localparam logic [5:0] OP_STORE = 6'b101011;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_END   = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_END   = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2,
        ST_HALTED = 2'd3
    } mem_state_t;

    function automatic logic isLoad(input logic [31:0] instr);
        return (instr[31:26] == OP_LOAD);
    endfunction

    function automatic logic isStore(input logic [31:0] instr);
        return (instr[31:26] == OP_STORE);
    endfunction

    function automatic logic isJAL(input logic [31:0] instr);
        return (instr[31:26] == OP_JAL);
    endfunction

    function automatic logic isEND(input logic [31:0] instr);
        return (instr[31:26] == OP_END) && (instr[5:0] == FN_END);
    endfunction

    function automatic logic isAluImm(input logic [31:0] instr);
        logic hit;
        case (instr[31:26])
            OP_ADDI, OP_ORI, OP_XORI, OP_SLTI: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Returns {we, rd}; a destination of r0 is never written.
    function automatic logic [5:0] wbDest(input logic [31:0] instr, input logic [4:0] link_reg);
        logic       we;
        logic [4:0] rd;
        we = 1'b0;
        rd = 5'd0;
        if ((instr[31:26] == OP_RTYPE) && (instr[5:0] != FN_JR)) begin
            we = 1'b1;
            rd = instr[15:11];
        end else if (isAluImm(instr) || isLoad(instr)) begin
            we = 1'b1;
            rd = instr[20:16];
        end else if (isJAL(instr)) begin
            we = 1'b1;
            rd = link_reg;
        end else begin
            we = 1'b0;
            rd = 5'd0;
        end
        if (rd == 5'd0) begin
            we = 1'b0;
        end else begin
            we = we;
        end
        return {we, rd};
    endfunction

endpackage

// File: rtl/mem_access_stage_dm_handshake.sv
// Data-memory req/ack sequencer: holds the request stable until ack or until
// the ack timeout expires, and reports completion/abort to the stage FSM.
module dm_handshake
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_data,
    output logic        dm_req,
    output logic        dm_wen,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timed_out
);

    localparam logic [7:0] CNT_LIMIT = 8'(ACK_TIMEOUT - 1);

    logic        req_q, req_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;

    // Completion and abort are seen in the same cycle as the ack (or last wait cycle).
    always_comb begin
        done      = req_q & dm_ack;
        rdata     = dm_data;
        timed_out = req_q & ~dm_ack & (cnt_q == CNT_LIMIT);
    end

    // Request, address/data hold and wait-cycle counter next state.
    always_comb begin
        req_d   = req_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (start) begin
            req_d   = 1'b1;
            wen_d   = is_store;
            addr_d  = addr;
            wdata_d = wdata;
            cnt_d   = 8'd0;
        end else if (done || timed_out) begin
            req_d = 1'b0;
            wen_d = 1'b0;
            cnt_d = 8'd0;
        end else if (req_q) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Handshake state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            req_q   <= req_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dm_req   = req_q;
    assign dm_wen   = wen_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access/writeback stage: accepts one executed instruction at a time,
// runs the data-memory access if needed and emits the register writeback strobe.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 16,
    parameter logic [4:0] LINK_REG    = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    output logic        e_ready,
    input  logic [31:0] e_instr,
    input  logic [31:0] e_result,
    input  logic [31:0] e_rt,
    output logic [31:0] addDM,
    output logic [31:0] dataOUT,
    output logic        wenDM,
    output logic        dm_req,
    input  logic        dm_ack,
    input  logic [31:0] dataDM,
    output logic        wbEnable,
    output logic [4:0]  wbRdID,
    output logic [31:0] wbData,
    output logic        misalign,
    output logic        timeout,
    output logic        halt
);

    mem_state_t  state_q, state_d;
    logic        e_ready_q, e_ready_d;
    logic        wb_enable_q, wb_enable_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic        halt_q, halt_d;
    logic        pend_load_q, pend_load_d;
    logic        pend_we_q, pend_we_d;
    logic [4:0]  pend_rd_q, pend_rd_d;

    logic        accept_s;
    logic        start_s;
    logic [5:0]  dest_s;
    logic        is_mem_s;
    logic        hs_done_s;
    logic        hs_timed_out_s;
    logic [31:0] hs_rdata_s;

    dm_handshake #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_dm_handshake (
        .clk       (clk),
        .rst_n     (reset),
        .start     (start_s),
        .is_store  (isStore(e_instr)),
        .addr      (e_result),
        .wdata     (e_rt),
        .dm_ack    (dm_ack),
        .dm_data   (dataDM),
        .dm_req    (dm_req),
        .dm_wen    (wenDM),
        .dm_addr   (addDM),
        .dm_wdata  (dataOUT),
        .done      (hs_done_s),
        .rdata     (hs_rdata_s),
        .timed_out (hs_timed_out_s)
    );

    // Stage FSM next state and registered output values.
    always_comb begin
        state_d     = state_q;
        wb_enable_d = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        halt_d      = halt_q;
        pend_load_d = pend_load_q;
        pend_we_d   = pend_we_q;
        pend_rd_d   = pend_rd_q;
        start_s     = 1'b0;
        accept_s    = e_valid & e_ready_q;
        dest_s      = wbDest(e_instr, LINK_REG);
        is_mem_s    = isLoad(e_instr) | isStore(e_instr);

        case (state_q)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (isEND(e_instr)) begin
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                end else if (is_mem_s && (e_result[1:0] == 2'b00)) begin
                    start_s     = 1'b1;
                    state_d     = ST_ACCESS;
                    pend_load_d = isLoad(e_instr);
                    pend_we_d   = dest_s[5];
                    pend_rd_d   = dest_s[4:0];
                end else if (is_mem_s) begin
                    misalign_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d     = ST_WB;
                    wb_enable_d = dest_s[5];
                    if (dest_s[5]) begin
                        wb_rd_d   = dest_s[4:0];
                        wb_data_d = e_result;
                    end else begin
                        wb_rd_d   = wb_rd_q;
                        wb_data_d = wb_data_q;
                    end
                end
            end
            ST_ACCESS: begin
                if (hs_done_s && pend_load_q) begin
                    state_d     = ST_WB;
                    wb_enable_d = pend_we_q;
                    if (pend_we_q) begin
                        wb_rd_d   = pend_rd_q;
                        wb_data_d = hs_rdata_s;
                    end else begin
                        wb_rd_d   = wb_rd_q;
                        wb_data_d = wb_data_q;
                    end
                end else if (hs_done_s) begin
                    state_d = ST_IDLE;
                end else if (hs_timed_out_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        e_ready_d = (state_d == ST_IDLE);
    end

    // Stage state and registered outputs; reset aborts everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            e_ready_q   <= 1'b1;
            wb_enable_q <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            halt_q      <= 1'b0;
            pend_load_q <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_rd_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            e_ready_q   <= e_ready_d;
            wb_enable_q <= wb_enable_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            halt_q      <= halt_d;
            pend_load_q <= pend_load_d;
            pend_we_q   <= pend_we_d;
            pend_rd_q   <= pend_rd_d;
        end
    end

    assign e_ready  = e_ready_q;
    assign wbEnable = wb_enable_q;
    assign wbRdID   = wb_rd_q;
    assign wbData   = wb_data_q;
    assign misalign = misalign_q;
    assign timeout  = timeout_q;
    assign halt     = halt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change and outputs are checked
// on the falling edge, half a cycle away from the active rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_instr;
    logic [31:0] e_result;
    logic [31:0] e_rt;
    logic [31:0] addDM;
    logic [31:0] dataOUT;
    logic        wenDM;
    logic        dm_req;
    logic        dm_ack;
    logic [31:0] dataDM;
    logic        wbEnable;
    logic [4:0]  wbRdID;
    logic [31:0] wbData;
    logic        misalign;
    logic        timeout;
    logic        halt;

    int tests = 0;
    int fails = 0;

    mem_access_stage #(.ACK_TIMEOUT(16), .LINK_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_ready(e_ready),
        .e_instr(e_instr), .e_result(e_result), .e_rt(e_rt),
        .addDM(addDM), .dataOUT(dataOUT), .wenDM(wenDM), .dm_req(dm_req),
        .dm_ack(dm_ack), .dataDM(dataDM), .wbEnable(wbEnable), .wbRdID(wbRdID),
        .wbData(wbData), .misalign(misalign), .timeout(timeout), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] res, input logic [31:0] rt);
        e_valid  = 1'b1;
        e_instr  = instr;
        e_result = res;
        e_rt     = rt;
    endtask

    initial begin
        reset = 1'b0; e_valid = 1'b0; e_instr = 32'd0; e_result = 32'd0;
        e_rt = 32'd0; dm_ack = 1'b0; dataDM = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_e_ready", 32'(e_ready), 32'd1);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_wenDM", 32'(wenDM), 32'd0);
        chk("rst_wbEnable", 32'(wbEnable), 32'd0);
        chk("rst_wbData", wbData, 32'd0);
        chk("rst_addDM", addDM, 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        reset = 1'b1;

        // R-type ADD rd=1
        @(negedge clk); offer(32'h0043_0820, 32'h0000_0007, 32'd0);
        @(negedge clk); e_valid = 1'b0;
        chk("add_wbEnable", 32'(wbEnable), 32'd1);
        chk("add_wbRdID", 32'(wbRdID), 32'd1);
        chk("add_wbData", wbData, 32'd7);
        chk("add_busy", 32'(e_ready), 32'd0);
        @(negedge clk);
        chk("add_strobe_end", 32'(wbEnable), 32'd0);
        chk("add_ready_back", 32'(e_ready), 32'd1);

        // Load rt=5, ack on 3rd ACCESS cycle
        offer(32'h8805_0000, 32'h0000_0100, 32'd0);
        @(negedge clk); e_valid = 1'b0;
        chk("ld_req_c1", 32'(dm_req), 32'd1);
        chk("ld_addr", addDM, 32'h0000_0100);
        chk("ld_wen", 32'(wenDM), 32'd0);
        @(negedge clk);
        chk("ld_req_c2", 32'(dm_req), 32'd1);
        @(negedge clk);
        chk("ld_req_c3", 32'(dm_req), 32'd1);
        chk("ld_no_wb_yet", 32'(wbEnable), 32'd0);
        dm_ack = 1'b1; dataDM = 32'hDEAD_BEEF;
        @(negedge clk); dm_ack = 1'b0; dataDM = 32'd0;
        chk("ld_req_drop", 32'(dm_req), 32'd0);
        chk("ld_wbEnable", 32'(wbEnable), 32'd1);
        chk("ld_wbRdID", 32'(wbRdID), 32'd5);
        chk("ld_wbData", wbData, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("ld_ready_back", 32'(e_ready), 32'd1);

        // Store with immediate ack
        offer(32'hAC02_0000, 32'h0000_0204, 32'h0000_1234);
        @(negedge clk); e_valid = 1'b0;
        chk("st_req", 32'(dm_req), 32'd1);
        chk("st_wen", 32'(wenDM), 32'd1);
        chk("st_data", dataOUT, 32'h0000_1234);
        chk("st_addr", addDM, 32'h0000_0204);
        dm_ack = 1'b1;
        @(negedge clk); dm_ack = 1'b0;
        chk("st_req_drop", 32'(dm_req), 32'd0);
        chk("st_wen_drop", 32'(wenDM), 32'd0);
        chk("st_no_wb", 32'(wbEnable), 32'd0);
        chk("st_ready", 32'(e_ready), 32'd1);

        // Misaligned store
        offer(32'hAC02_0000, 32'h0000_0102, 32'h0000_5555);
        @(negedge clk); e_valid = 1'b0;
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_no_req", 32'(dm_req), 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_no_req2", 32'(dm_req), 32'd0);
        chk("mis_ready", 32'(e_ready), 32'd1);

        // Load that never gets an ack
        offer(32'h8805_0000, 32'h0000_0300, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); e_valid = 1'b0;
            chk($sformatf("to_req_c%0d", k), 32'(dm_req), 32'd1);
            chk($sformatf("to_quiet_c%0d", k), 32'(timeout), 32'd0);
        end
        @(negedge clk);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_req_drop", 32'(dm_req), 32'd0);
        chk("to_no_wb", 32'(wbEnable), 32'd0);
        chk("to_ready", 32'(e_ready), 32'd1);
        dm_ack = 1'b1; dataDM = 32'h0BAD_0BAD;
        @(negedge clk); dm_ack = 1'b0;
        chk("to_pulse_end", 32'(timeout), 32'd0);
        chk("late_ack_no_wb", 32'(wbEnable), 32'd0);
        chk("late_ack_no_req", 32'(dm_req), 32'd0);

        // JAL, ORI, ADDI to r0, JR
        offer(32'h0C00_0010, 32'h0000_0040, 32'd0);
        @(negedge clk); e_valid = 1'b0;
        chk("jal_we", 32'(wbEnable), 32'd1);
        chk("jal_rd", 32'(wbRdID), 32'd31);
        chk("jal_data", wbData, 32'h0000_0040);
        @(negedge clk); offer(32'h3407_00FF, 32'h0000_00FF, 32'd0);
        @(negedge clk); e_valid = 1'b0;
        chk("ori_we", 32'(wbEnable), 32'd1);
        chk("ori_rd", 32'(wbRdID), 32'd7);
        chk("ori_data", wbData, 32'h0000_00FF);
        @(negedge clk); offer(32'h2000_0005, 32'h0000_0005, 32'd0);
        @(negedge clk); e_valid = 1'b0;
        chk("addi_r0_no_we", 32'(wbEnable), 32'd0);
        @(negedge clk); offer(32'h03E0_0008, 32'h0000_0080, 32'd0);
        @(negedge clk); e_valid = 1'b0;
        chk("jr_no_we", 32'(wbEnable), 32'd0);

        // END halts; later offers are ignored
        @(negedge clk); offer(32'hFC00_003F, 32'd0, 32'd0);
        @(negedge clk);
        chk("end_halt", 32'(halt), 32'd1);
        chk("end_not_ready", 32'(e_ready), 32'd0);
        offer(32'h0043_0820, 32'h0000_0009, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("halted_ready_c%0d", k), 32'(e_ready), 32'd0);
            chk($sformatf("halted_no_wb_c%0d", k), 32'(wbEnable), 32'd0);
        end
        chk("halted_sticky", 32'(halt), 32'd1);
        e_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_clears_halt", 32'(halt), 32'd0);
        chk("rst_ready_async", 32'(e_ready), 32'd1);
        @(negedge clk); reset = 1'b1;

        // Reset asserted mid-ACCESS of a store
        @(negedge clk); offer(32'hAC02_0000, 32'h0000_0208, 32'h0000_ABCD);
        @(negedge clk); e_valid = 1'b0;
        chk("mid_req", 32'(dm_req), 32'd1);
        chk("mid_wen", 32'(wenDM), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(dm_req), 32'd0);
        chk("mid_rst_wen", 32'(wenDM), 32'd0);
        chk("mid_rst_addr", addDM, 32'd0);
        chk("mid_rst_data", dataOUT, 32'd0);
        chk("mid_rst_wb", 32'(wbEnable), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(e_ready), 32'd1);
        chk("post_rst_req", 32'(dm_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
